pulse_timestamp_fifo: RTL and testbench
=======================================

# pulse_timestamp_fifo

Front-end capture stage for the orbital pulse input. It synchronises the raw asynchronous pulse pin and detects rising edges. Each edge is stamped with a free-running cycle timebase and the stamp is queued in a first-word-fall-through FIFO. The single-cycle edge strobe feeds the pulse/edge counters and burst search. The FIFO head is read by the SPI readout path.

## Interface
Parameters:
- WIDTH, 32, timestamp and timebase width in bits
- DEPTH, 16, FIFO entries; power of two, minimum 2
- OVF_WIDTH, 16, width of the overflow drop counter

Ports:
- iCLK  in  1  system clock; the only clock
- iRESETn  in  1  reset, asynchronous, active-low
- iPULSE  in  1  raw asynchronous pulse pin
- iCLEAR  in  1  synchronous flush; tied to SPI slave-select high
- iPOP  in  1  remove FIFO head; ignored when empty
- oEDGE  out  1  one-cycle strobe per detected rising edge
- oDATA  out  WIDTH  timestamp at FIFO head; 0 when empty
- oVALID  out  1  FIFO not empty
- oCOUNT  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
- oFULL  out  1  oCOUNT == DEPTH
- oOVF_CNT  out  OVF_WIDTH  edges dropped while full; saturating

## Operation
- Reset (iRESETn low, any time): the following registers clear to 0 immediately, independent of iCLK:
  - sync flops s1, s2, s3
  - timebase
  - read and write pointers, occupancy
  - overflow count
  - oEDGE
- All outputs are 0 during reset. FIFO storage RAM is not reset.
- Synchroniser: s1 <= iPULSE, s2 <= s1, s3 <= s2. Detect condition is s2 & ~s3.
- Timebase: a WIDTH-bit counter that increments on every clock edge and wraps from all-ones to 0.
- Push: on a clock edge where detect is true:
  - oEDGE is set to 1 for that cycle only.
  - A push request carries the pre-edge timebase value.
- Pop request: iPOP & oVALID.
- FIFO actions per edge:
  - Push only, not full: write at the write pointer, wptr+1, count+1.
  - Push only, full: entry dropped, count unchanged, oOVF_CNT+1. The counter saturates at all-ones.
  - Pop only: rptr+1, count-1.
  - Push and pop together, including when full: both occur, count unchanged, no drop. The pushed stamp becomes visible behind the existing entries.
  - Push and pop together when empty: pop is ignored, push occurs.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is a separate counter.
- First-word fall-through: oDATA = mem[rptr] whenever oVALID=1, and 0 otherwise.
- iCLEAR, sampled at the clock edge, has priority over push and pop. It zeroes:
  - timebase
  - pointers and occupancy
  - oOVF_CNT
  - oEDGE
- iCLEAR does not touch s1..s3. An edge pending in the synchroniser at clear release is still detected later, stamped relative to the new timebase.

## Timing
- Pulse latency: let iPULSE be first sampled high at edge k.
  - s2=1 after edge k+1.
  - Detection, oEDGE high and FIFO write happen at edge k+2.
  - oVALID rises after edge k+2 if the FIFO was empty.
- Timestamp numbering: edge 0 is the first edge after iRESETn deasserts or iCLEAR is sampled high. The pre-edge timebase value at edge n equals n. The stamp written at edge k+2 is therefore k+2.
- Capture guarantee: iPULSE high ≥2 cycles and low ≥2 cycles is always captured. Shorter pulses may be missed. A pulse is never counted twice.
- Pop handshake: oDATA and oVALID update on the edge that consumes iPOP. Back-to-back pops drain one entry per cycle.
- oCOUNT, oFULL and oOVF_CNT are registered and update on the same edge as the push or pop that changes them.

## Test plan
- Reset, then iPULSE high for 3 cycles starting before edge 10: oEDGE is high one cycle at edge 12; oVALID=1; oDATA=12; oCOUNT=1.
- 16 pulses with 6-cycle period, then 3 more, no pops (DEPTH=16):
  - oFULL=1; oOVF_CNT=3.
  - Pop 16 times: stamps are strictly increasing in steps of 6, then oVALID=0 and oDATA=0.
- Full FIFO, iPOP held high on the cycle an edge is detected: oCOUNT stays 16, oOVF_CNT unchanged, new stamp is the last entry read out.
- iCLEAR high for one cycle with 5 entries queued and oOVF_CNT=2: next cycle oCOUNT=0, oVALID=0, oOVF_CNT=0. A pulse sampled at the edge 4 cycles after clear yields stamp 6.
- Assert iRESETn low mid-burst, asynchronously between clock edges:
  - All outputs are 0 before the next iCLK edge.
  - After release, the first stamp is referenced to timebase 0.
  - iPOP on an empty FIFO does nothing; oCOUNT never underflows.
- Timebase wrap with WIDTH=8: a pulse detected at pre-edge timebase 255 stamps 255; the next pulse 4 cycles later stamps 3.

Source files
------------

// File: rtl/pulse_timestamp_fifo.sv
// pulse_timestamp_fifo: synchronise a pulse pin, strobe rising edges and queue their timestamps in a FWFT FIFO.
module pulse_timestamp_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int OVF_WIDTH = 16
) (
  input  logic                   iCLK,
  input  logic                   iRESETn,
  input  logic                   iPULSE,
  input  logic                   iCLEAR,
  input  logic                   iPOP,
  output logic                   oEDGE,
  output logic [WIDTH-1:0]       oDATA,
  output logic                   oVALID,
  output logic [$clog2(DEPTH):0] oCOUNT,
  output logic                   oFULL,
  output logic [OVF_WIDTH-1:0]   oOVF_CNT
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic s1_q, s2_q, s3_q;
  logic edge_q, edge_d;
  logic [WIDTH-1:0] tb_q, tb_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [OVF_WIDTH-1:0] ovf_q, ovf_d;
  logic detect, full, pop, wr, drop;
  always_comb begin
    detect = s2_q & ~s3_q;
    full   = cnt_q == (AW+1)'(DEPTH);
    pop    = ~iCLEAR & iPOP & (cnt_q != '0);
    // a simultaneous pop frees the slot, so a full FIFO still accepts the push
    wr     = ~iCLEAR & detect & (~full | pop);
    drop   = ~iCLEAR & detect & full & ~pop;
    edge_d = ~iCLEAR & detect;
    tb_d   = iCLEAR ? '0 : tb_q + WIDTH'(1);
    wptr_d = iCLEAR ? '0 : wptr_q + AW'(wr);
    rptr_d = iCLEAR ? '0 : rptr_q + AW'(pop);
    cnt_d  = iCLEAR ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d  = iCLEAR ? '0 : (drop & ~&ovf_q) ? ovf_q + OVF_WIDTH'(1) : ovf_q;
  end
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      edge_q <= 1'b0;
      tb_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      s1_q   <= iPULSE;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      edge_q <= edge_d;
      tb_q   <= tb_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
  always_ff @(posedge iCLK) begin
    if (wr) mem[wptr_q] <= tb_q;
  end
  assign oEDGE    = edge_q;
  assign oVALID   = cnt_q != '0;
  assign oDATA    = oVALID ? mem[rptr_q] : '0;
  assign oCOUNT   = cnt_q;
  assign oFULL    = full;
  assign oOVF_CNT = ovf_q;
endmodule

// File: tb/tb_pulse_timestamp_fifo.sv
// tb_pulse_timestamp_fifo: directed stimulus checked against a queue-based model plus hand-computed stamps.
module tb_pulse_timestamp_fifo;
  localparam int W = 32, D = 16, OW = 16;
  logic clk = 1'b0, rst_n = 1'b1, pulse = 1'b0, clear = 1'b0, pop = 1'b0;
  logic edge_o, valid_o, full_o;
  logic [W-1:0] data_o;
  logic [4:0] count_o;
  logic [OW-1:0] ovf_o;
  logic p8 = 1'b0, clr8 = 1'b0, pop8 = 1'b0;
  logic edge8, valid8, full8;
  logic [7:0] data8;
  logic [2:0] count8;
  logic [3:0] ovf8;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pulse_timestamp_fifo #(.WIDTH(W), .DEPTH(D), .OVF_WIDTH(OW)) u_dut (
    .iCLK(clk), .iRESETn(rst_n), .iPULSE(pulse), .iCLEAR(clear), .iPOP(pop),
    .oEDGE(edge_o), .oDATA(data_o), .oVALID(valid_o), .oCOUNT(count_o),
    .oFULL(full_o), .oOVF_CNT(ovf_o));
  pulse_timestamp_fifo #(.WIDTH(8), .DEPTH(4), .OVF_WIDTH(4)) u_dut8 (
    .iCLK(clk), .iRESETn(rst_n), .iPULSE(p8), .iCLEAR(clr8), .iPOP(pop8),
    .oEDGE(edge8), .oDATA(data8), .oVALID(valid8), .oCOUNT(count8),
    .oFULL(full8), .oOVF_CNT(ovf8));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic pulses(input int n);
    repeat (n) begin
      pulse = 1'b1; cyc(3);
      pulse = 1'b0; cyc(3);
    end
  endtask
  task automatic do_clear;
    clear = 1'b1; cyc(1); clear = 1'b0;
  endtask
  // Model: the pin is seen two edges late; a rising edge in the delayed stream pushes the cycle number.
  logic [2:0] hist = '0;
  logic [W-1:0] m_tb = '0;
  logic [W-1:0] q[$];
  int m_ovf = 0;
  logic m_edge = 1'b0, m_det, m_full, m_pop;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist = '0; m_tb = '0; q.delete(); m_ovf = 0; m_edge = 1'b0;
    end else begin
      m_det  = hist[1] & ~hist[2];
      m_full = q.size() == D;
      m_pop  = pop && q.size() > 0;
      hist   = {hist[1:0], pulse};
      if (clear) begin
        m_tb = '0; q.delete(); m_ovf = 0; m_edge = 1'b0;
      end else begin
        m_edge = m_det;
        if (m_pop) void'(q.pop_front());
        if (m_det) begin
          if (!m_full || m_pop) q.push_back(m_tb);
          else if (m_ovf < 65535) m_ovf++;
        end
        m_tb = m_tb + W'(1);
      end
    end
  end
  always @(negedge clk) begin
    chk("edge", 64'(edge_o), 64'(m_edge));
    chk("valid", 64'(valid_o), 64'(q.size() > 0));
    chk("data", 64'(data_o), 64'(q.size() > 0 ? q[0] : W'(0)));
    chk("count", 64'(count_o), 64'(q.size()));
    chk("full", 64'(full_o), 64'(q.size() == D));
    chk("ovf", 64'(ovf_o), 64'(m_ovf));
  end
  initial begin
    #1 rst_n = 1'b0;
    #1 chk("rst count", 64'(count_o), 64'd0);
    chk("rst valid", 64'(valid_o), 64'd0);
    cyc(3); rst_n = 1'b1;
    cyc(10); pulse = 1'b1; cyc(2);
    chk("t1 edge early", 64'(edge_o), 64'd0);
    cyc(1); pulse = 1'b0;
    chk("t1 edge", 64'(edge_o), 64'd1);
    chk("t1 valid", 64'(valid_o), 64'd1);
    chk("t1 data", 64'(data_o), 64'd12);
    chk("t1 count", 64'(count_o), 64'd1);
    cyc(1);
    chk("t1 edge once", 64'(edge_o), 64'd0);
    do_clear; pulses(19);
    chk("t2 full", 64'(full_o), 64'd1);
    chk("t2 ovf", 64'(ovf_o), 64'd3);
    chk("t2 count", 64'(count_o), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("t2 stamp", 64'(data_o), 64'(2 + 6 * i));
      pop = 1'b1; cyc(1); pop = 1'b0;
    end
    chk("t2 empty valid", 64'(valid_o), 64'd0);
    chk("t2 empty data", 64'(data_o), 64'd0);
    do_clear; pulses(17);
    chk("t3 ovf before", 64'(ovf_o), 64'd1);
    pulse = 1'b1; cyc(2);
    pop = 1'b1; cyc(1); pop = 1'b0; pulse = 1'b0;
    chk("t3 edge", 64'(edge_o), 64'd1);
    chk("t3 count", 64'(count_o), 64'd16);
    chk("t3 ovf", 64'(ovf_o), 64'd1);
    chk("t3 head", 64'(data_o), 64'd8);
    cyc(3);
    for (int i = 0; i < 15; i++) begin
      chk("t3 stamp", 64'(data_o), 64'(8 + 6 * i));
      pop = 1'b1; cyc(1); pop = 1'b0;
    end
    chk("t3 last stamp", 64'(data_o), 64'd104);
    pop = 1'b1; cyc(1); pop = 1'b0;
    chk("t3 drained", 64'(valid_o), 64'd0);
    do_clear; pulses(18);
    pop = 1'b1; cyc(11); pop = 1'b0;
    chk("t4 count", 64'(count_o), 64'd5);
    chk("t4 ovf", 64'(ovf_o), 64'd2);
    chk("t4 head", 64'(data_o), 64'd68);
    do_clear;
    chk("t4 clr count", 64'(count_o), 64'd0);
    chk("t4 clr valid", 64'(valid_o), 64'd0);
    chk("t4 clr ovf", 64'(ovf_o), 64'd0);
    cyc(4); pulse = 1'b1; cyc(3); pulse = 1'b0;
    chk("t4 edge", 64'(edge_o), 64'd1);
    chk("t4 stamp", 64'(data_o), 64'd6);
    chk("t4 count1", 64'(count_o), 64'd1);
    cyc(3);
    pulse = 1'b1; cyc(2); pulse = 1'b0; cyc(2);
    pulse = 1'b1; cyc(1); pulse = 1'b0; cyc(2);
    pulse = 1'b1; cyc(2); pulse = 1'b0; cyc(3);
    pulse = 1'b1; cyc(1);
    chk("t5 valid pre", 64'(valid_o), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("t5 edge", 64'(edge_o), 64'd0);
    chk("t5 valid", 64'(valid_o), 64'd0);
    chk("t5 data", 64'(data_o), 64'd0);
    chk("t5 count", 64'(count_o), 64'd0);
    chk("t5 full", 64'(full_o), 64'd0);
    chk("t5 ovf", 64'(ovf_o), 64'd0);
    pulse = 1'b0; cyc(2); rst_n = 1'b1;
    pop = 1'b1; cyc(2); pop = 1'b0;
    chk("t5 empty pop count", 64'(count_o), 64'd0);
    chk("t5 empty pop valid", 64'(valid_o), 64'd0);
    pulse = 1'b1; cyc(3); pulse = 1'b0;
    chk("t5 edge after", 64'(edge_o), 64'd1);
    chk("t5 stamp", 64'(data_o), 64'd4);
    clr8 = 1'b1; cyc(1); clr8 = 1'b0;
    cyc(253);
    p8 = 1'b1; cyc(2); p8 = 1'b0; cyc(2);
    p8 = 1'b1; cyc(2); p8 = 1'b0; cyc(3);
    chk("t6 count", 64'(count8), 64'd2);
    chk("t6 stamp 255", 64'(data8), 64'd255);
    pop8 = 1'b1; cyc(1); pop8 = 1'b0;
    chk("t6 stamp wrap", 64'(data8), 64'd3);
    chk("t6 count1", 64'(count8), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
